mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control unit; successor to the single-cycle controller. Sequences each
//  instruction through an FSM that shares one ALU and one memory port. Adds wait-state memory
//  handshake, optional extended ISA (bne/andi/ori) and parametrised ALU-control width.
//  Drives the multicycle datapath; instruction word comes from its IR (op=IR[31:26], funct=IR[5:0]).
// PARAMETERS
//  EXT_ISA    1  1: decode bne/andi/ori; 0: those opcodes treated as illegal
//  ALUCTRL_W  3  alucontrol width (>=3); bits above [2:0] driven 0
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high
//  op           in   6          opcode from IR
//  funct        in   6          function field from IR
//  zero         in   1          ALU zero flag
//  mem_ready    in   1          memory completes current access this cycle
//  mem_req      out  1          memory access in progress
//  iord         out  1          0: address=PC, 1: address=ALUOut
//  memwrite     out  1          store strobe (valid while mem_req)
//  irwrite      out  1          load IR
//  regdst       out  1          1: rd, 0: rt
//  memtoreg     out  1          1: writeback from data reg
//  regwrite     out  1          register-file write
//  alusrca      out  1          0: PC, 1: A reg
//  alusrcb      out  2          00 B, 01 const 4, 10 imm, 11 imm<<2
//  extop        out  1          1 sign-extend imm, 0 zero-extend
//  pcsrc        out  2          00 ALUResult, 01 ALUOut, 10 jump target
//  pcen         out  1          PC write enable
//  alucontrol   out  ALUCTRL_W  010 add,110 sub,000 and,001 or,111 slt
//  illegal      out  1          1-cycle pulse on undecodable op/funct
// BEHAVIOUR
//  - State register only sequential element; outputs Moore-decoded from state plus
//    mem_ready/zero gating. reset -> state FETCH asynchronously; while reset high all
//    strobes (mem_req,memwrite,irwrite,regwrite,pcen,illegal) = 0, others 0.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BREX, IMMEX, IMMWB, JEX.
//  - FETCH: mem_req=1,iord=0,alusrca=0,alusrcb=01,add,pcsrc=00; irwrite=pcen=mem_ready.
//    Stay while !mem_ready; -> DECODE when mem_ready.
//  - DECODE: alusrca=0,alusrcb=11,add,extop=1 (branch target to ALUOut). Next by op:
//    lw/sw(100011/101011)->MEMADR; R(000000)->REXEC; beq(000100), bne(000101)*->BREX;
//    addi(001000), andi(001100)*, ori(001101)*->IMMEX; j(000010)->JEX; else illegal=1 ->FETCH.
//    (* only when EXT_ISA=1.)
//  - MEMADR: alusrca=1,alusrcb=10,extop=1,add; lw->MEMRD, sw->MEMWR.
//  - MEMRD: mem_req=1,iord=1; wait on mem_ready -> MEMWB. MEMWB: regdst=0,memtoreg=1,regwrite=1.
//  - MEMWR: mem_req=1,iord=1,memwrite=1; wait on mem_ready -> FETCH.
//  - REXEC: alusrca=1,alusrcb=00; funct 100000 add,100010 sub,100100 and,100101 or,101010 slt;
//    other funct: illegal=1 -> FETCH, no writeback. Valid -> RWB (regdst=1,memtoreg=0,regwrite=1).
//  - BREX: alusrca=1,alusrcb=00,sub,pcsrc=01; pcen = zero (beq) or !zero (bne).
//  - IMMEX: alusrca=1,alusrcb=10; addi add/extop=1, andi and/extop=0, ori or/extop=0.
//    IMMWB: regdst=0,memtoreg=0,regwrite=1. JEX: pcsrc=10,pcen=1.
//  - Terminal states (MEMWB,MEMWR done,RWB,BREX,IMMWB,JEX) -> FETCH next cycle.
//  - CPI (mem_ready tied 1): lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3.
//    Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle; no output other than
//    mem_req/iord/memwrite asserted while waiting.
//  - mem_ready outside memory states ignored. Reset mid-instruction aborts; no pending write.
//  - Unused/unreachable state encodings -> FETCH.
// TESTING
//  - reset high 3 cyc, release, op=100011, mem_ready=1 -> states F,D,MA,MR,WB; regwrite only cycle 5.
//  - sw with mem_ready=0 for 2 cyc in MEMWR -> memwrite/mem_req high 3 cyc, then FETCH; total 6.
//  - beq zero=1 -> pcen=1,pcsrc=01 in BREX; zero=0 -> pcen=0; bne inverse (EXT_ISA=1).
//  - EXT_ISA=0, op=001101 -> illegal pulse in DECODE, next state FETCH, no regwrite.
//  - R-type funct=101010 -> alucontrol=111 in REXEC; funct=000000 -> illegal, no RWB.
//  - assert reset during MEMRD wait -> all strobes 0 immediately; after release FETCH, mem_req=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: one FSM sequences fetch, decode, execute, memory and
// writeback over a shared ALU and a single wait-stated memory port.
module mips_multicycle_ctrl #(
  parameter bit EXT_ISA   = 1'b1,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 extop,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BREX   = 4'd8;
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state, state_next;
  logic [2:0] alu_op;
  logic       is_bne, is_andi, is_ori;

  // Extended opcodes fall through to the illegal path when the option is off.
  assign is_bne  = EXT_ISA && (op == OP_BNE);
  assign is_andi = EXT_ISA && (op == OP_ANDI);
  assign is_ori  = EXT_ISA && (op == OP_ORI);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = S_FETCH;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    extop      = 1'b0;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    alu_op     = ALU_AND;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alu_op     = ALU_ADD;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        extop   = 1'b1;
        alu_op  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_REXEC;
          OP_BEQ:       state_next = S_BREX;
          OP_ADDI:      state_next = S_IMMEX;
          OP_J:         state_next = S_JEX;
          default: begin
            if (is_bne)                 state_next = S_BREX;
            else if (is_andi || is_ori) state_next = S_IMMEX;
            else                        illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 1'b1;
        alu_op  = ALU_ADD;
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
      end
      S_MEMRD: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        alusrca    = 1'b1;
        state_next = S_RWB;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BREX: begin
        alusrca = 1'b1;
        alu_op  = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = is_bne ? !zero : zero;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_IMMWB;
        if (is_andi)     alu_op = ALU_AND;
        else if (is_ori) alu_op = ALU_OR;
        else begin
          alu_op = ALU_ADD;
          extop  = 1'b1;
        end
      end
      S_IMMWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset is asynchronous, so the decoded outputs must go quiet combinationally too.
    if (reset) begin
      {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca} = '0;
      {alusrcb, extop, pcsrc, pcen, illegal} = '0;
      alu_op = 3'b000;
    end
  end

  assign alucontrol = ALUCTRL_W'(alu_op);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control outputs, checked with immediate assertions.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alu;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic  mr;
    logic  z;
    outs_t e;
    outs_t m;
    outs_t e0;
    outs_t m0;
  } cyc_t;

  typedef enum {K_ILL, K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_ANDI, K_ORI, K_J} kind_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       extop, pcen, illegal;
  logic [2:0] alucontrol;

  logic       b_mem_req, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite;
  logic       b_alusrca, b_extop, b_pcen, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [4:0] b_alucontrol;

  outs_t obs, obs0;
  cyc_t  q[$];
  string tag;
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.EXT_ISA(1'b1), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .extop(extop), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  mips_multicycle_ctrl #(.EXT_ISA(1'b0), .ALUCTRL_W(5)) dut_base (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .extop(b_extop), .pcsrc(b_pcsrc), .pcen(b_pcen),
    .alucontrol(b_alucontrol), .illegal(b_illegal)
  );

  always_comb begin
    obs  = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, extop, pcsrc, pcen, alucontrol, illegal};
    obs0 = {b_mem_req, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
            b_alusrca, b_alusrcb, b_extop, b_pcsrc, b_pcen, b_alucontrol[2:0], b_illegal};
  end

  task automatic check(input string tg, input logic [17:0] ob, input logic [17:0] ex,
                       input logic [17:0] m);
    vectors++;
    assert ((ob & m) === (ex & m)) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tg, ob & m, ex & m);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] o);
    case (o)
      6'd35:   return K_LW;
      6'd43:   return K_SW;
      6'd0:    return K_R;
      6'd4:    return K_BEQ;
      6'd5:    return K_BNE;
      6'd8:    return K_ADDI;
      6'd12:   return K_ANDI;
      6'd13:   return K_ORI;
      6'd2:    return K_J;
      default: return K_ILL;
    endcase
  endfunction

  // {legal, alu code} for an R-type function field.
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    case (f)
      6'd32:   return 4'b1_010;
      6'd34:   return 4'b1_110;
      6'd36:   return 4'b1_000;
      6'd37:   return 4'b1_001;
      6'd42:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  task automatic push(input logic mr, input logic z, input outs_t e, input outs_t m);
    cyc_t c;
    c.mr = mr;  c.z = z;  c.e = e;  c.m = m;  c.e0 = '0;  c.m0 = '0;
    q.push_back(c);
  endtask

  // Expand one instruction into expected cycles; wf/wm = wait cycles in fetch/memory access.
  task automatic instr(input string name, input logic [5:0] o, input logic [5:0] f,
                       input int wf, input int wm, input int zsel);
    outs_t e, all, m_alu;
    logic  z;
    kind_t k;
    logic [3:0] rd;
    all = '1;
    tag = name;
    op = o;
    funct = f;
    k = classify(o);

    e = '0;  e.mem_req = 1'b1;  e.alusrcb = 2'b01;  e.alu = 3'b010;
    repeat (wf) push(1'b0, 1'($urandom), e, all);
    e.irwrite = 1'b1;  e.pcen = 1'b1;
    push(1'b1, 1'($urandom), e, all);

    e = '0;  e.alusrcb = 2'b11;  e.extop = 1'b1;  e.alu = 3'b010;  e.illegal = (k == K_ILL);
    push(1'($urandom), 1'($urandom), e, all);

    e = '0;
    case (k)
      K_LW, K_SW: begin
        e.alusrca = 1'b1;  e.alusrcb = 2'b10;  e.extop = 1'b1;  e.alu = 3'b010;
        push(1'($urandom), 1'($urandom), e, all);
        e = '0;  e.mem_req = 1'b1;  e.iord = 1'b1;  e.memwrite = (k == K_SW);
        repeat (wm) push(1'b0, 1'($urandom), e, all);
        push(1'b1, 1'($urandom), e, all);
        if (k == K_LW) begin
          e = '0;  e.memtoreg = 1'b1;  e.regwrite = 1'b1;
          push(1'($urandom), 1'($urandom), e, all);
        end
      end
      K_R: begin
        rd = r_decode(f);
        e.alusrca = 1'b1;  e.alu = rd[2:0];  e.illegal = !rd[3];
        m_alu = all;
        if (!rd[3]) m_alu.alu = 3'b000;
        push(1'($urandom), 1'($urandom), e, m_alu);
        if (rd[3]) begin
          e = '0;  e.regdst = 1'b1;  e.regwrite = 1'b1;
          push(1'($urandom), 1'($urandom), e, all);
        end
      end
      K_BEQ, K_BNE: begin
        z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        e.alusrca = 1'b1;  e.alu = 3'b110;  e.pcsrc = 2'b01;
        e.pcen = (k == K_BEQ) ? z : !z;
        push(1'($urandom), z, e, all);
      end
      K_ADDI, K_ANDI, K_ORI: begin
        e.alusrca = 1'b1;  e.alusrcb = 2'b10;  e.extop = (k == K_ADDI);
        e.alu = (k == K_ADDI) ? 3'b010 : (k == K_ANDI) ? 3'b000 : 3'b001;
        push(1'($urandom), 1'($urandom), e, all);
        e = '0;  e.regwrite = 1'b1;
        push(1'($urandom), 1'($urandom), e, all);
      end
      K_J: begin
        e.pcsrc = 2'b10;  e.pcen = 1'b1;
        push(1'($urandom), 1'($urandom), e, all);
      end
      default: ;
    endcase
  endtask

  // Apply up to n queued cycles starting at posedge+1; leaves time at posedge+1.
  task automatic run_q(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.mr;
      zero = c.z;
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i), obs, c.e, c.m);
      if (c.m0 != '0) begin
        check($sformatf("%s base cyc%0d", tag, i), obs0, c.e0, c.m0);
        check($sformatf("%s base alu upper", tag), {16'b0, b_alucontrol[4:3]}, 18'b0, '1);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 10))
      0:       return 6'd35;
      1:       return 6'd43;
      2, 3:    return 6'd0;
      4:       return 6'd4;
      5:       return 6'd5;
      6:       return 6'd8;
      7:       return 6'd12;
      8:       return 6'd13;
      9:       return 6'd2;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 6))
      0:       return 6'd32;
      1:       return 6'd34;
      2:       return 6'd36;
      3:       return 6'd37;
      4:       return 6'd42;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    cyc_t c;
    outs_t fw;
    reset = 1'b1;  op = '0;  funct = '0;  zero = 1'b0;  mem_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), obs, 18'b0, '1);
      check($sformatf("reset base cyc%0d", i), {obs0[17:4], b_alucontrol[4:3], obs0[0:0], 1'b0},
            18'b0, '1);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    instr("lw", 6'b100011, 6'd0, 0, 0, -1);
    run_q(q.size());

    // Base variant must reject ori in DECODE and be back in FETCH next cycle.
    instr("ori", 6'b001101, 6'd7, 0, 0, -1);
    c = q[1];  c.e0 = c.e;  c.e0.illegal = 1'b1;  c.m0 = '1;  q[1] = c;
    fw = '0;  fw.mem_req = 1'b1;  fw.alusrcb = 2'b01;  fw.alu = 3'b010;
    c = q[2];  c.mr = 1'b0;  c.e0 = fw;  c.m0 = '1;  q[2] = c;
    run_q(q.size());

    instr("sw wait2", 6'b101011, 6'd0, 0, 2, -1);
    run_q(q.size());
    instr("beq z1", 6'b000100, 6'd0, 0, 0, 1);
    run_q(q.size());
    instr("beq z0", 6'b000100, 6'd0, 0, 0, 0);
    run_q(q.size());
    instr("bne z1", 6'b000101, 6'd0, 0, 0, 1);
    run_q(q.size());
    instr("bne z0", 6'b000101, 6'd0, 0, 0, 0);
    run_q(q.size());
    instr("slt", 6'b000000, 6'b101010, 0, 0, -1);
    run_q(q.size());
    instr("r funct0", 6'b000000, 6'b000000, 0, 0, -1);
    run_q(q.size());
    instr("lw fwait", 6'b100011, 6'd0, 2, 1, -1);
    run_q(q.size());
    instr("j", 6'b000010, 6'd0, 1, 0, -1);
    run_q(q.size());
    instr("addi", 6'b001000, 6'd0, 0, 0, -1);
    run_q(q.size());
    instr("andi", 6'b001100, 6'd0, 0, 0, -1);
    run_q(q.size());
    instr("illegal op", 6'b111111, 6'd0, 0, 0, -1);
    run_q(q.size());

    // Abort a load while it waits on memory: outputs must drop as soon as reset rises.
    instr("lw abort", 6'b100011, 6'd0, 0, 5, -1);
    run_q(4);
    mem_ready = 1'b0;
    #1;
    fw = '0;  fw.mem_req = 1'b1;  fw.iord = 1'b1;
    check("lw abort pre-reset", obs, fw, '1);
    reset = 1'b1;
    #1;
    check("async reset", obs, 18'b0, '1);
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset held", obs, 18'b0, '1);
    @(posedge clk);
    #1 reset = 1'b0;
    instr("after reset", 6'b001000, 6'd0, 0, 0, -1);
    run_q(q.size());

    for (int n = 0; n < 300; n++) begin
      instr($sformatf("rnd%0d", n), pick_op(), pick_funct(),
            $urandom_range(0, 2), $urandom_range(0, 2), -1);
      run_q(q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
